// File: rtl/deque_pkg.sv
// Shared definitions for the double-ended queue: end-select encoding and
// the occupancy-count width helper.
package deque_pkg;

  localparam logic END_FRONT = 1'b0;
  localparam logic END_BACK  = 1'b1;

  // Counter must hold 0..words inclusive, hence words+1 states.
  function automatic int cnt_width(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/deque_ring_ptr.sv
// Circular index step: next and previous index with explicit wrap at WORDS,
// so capacities that are not a power of two wrap correctly.
module deque_ring_ptr #(
  parameter int WORDS = 16
) (
  input  logic [$clog2(WORDS)-1:0] idx,
  output logic [$clog2(WORDS)-1:0] inc,
  output logic [$clog2(WORDS)-1:0] dec
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  always_comb begin
    inc = (idx == LAST) ? '0 : idx + 1'b1;
    dec = (idx == '0) ? LAST : idx - 1'b1;
  end

endmodule

// File: rtl/deque.sv
// Bus-selected double-ended queue on a circular register array, with push,
// pop and replace at either end plus sticky overflow/underflow flags.
module deque
  import deque_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 16,
  parameter int ADDR  = 0,
  parameter int SELW  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SELW-1:0]               select,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          end_sel,
  input  logic [WIDTH-1:0]              data_in,
  output logic [WIDTH-1:0]              front_out,
  output logic [WIDTH-1:0]              back_out,
  output logic [cnt_width(WORDS)-1:0]   count,
  output logic                          empty,
  output logic                          full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = cnt_width(WORDS);

  logic [WIDTH-1:0] mem [WORDS];
  logic [IW-1:0]    head, tail;
  logic [IW-1:0]    head_inc, head_dec, tail_inc, tail_dec;
  logic [CW-1:0]    cnt;
  logic             sel_q;
  logic             active;

  deque_ring_ptr #(.WORDS(WORDS)) u_head_ptr (
    .idx (head),
    .inc (head_inc),
    .dec (head_dec)
  );

  deque_ring_ptr #(.WORDS(WORDS)) u_tail_ptr (
    .idx (tail),
    .inc (tail_inc),
    .dec (tail_dec)
  );

  assign active = (select == SELW'(ADDR));
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(WORDS));
  assign count  = cnt;

  // push&pop on an empty deque falls through to the plain-push branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      sel_q     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!active) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= 1'b1;
      if (push && pop && !empty) begin
        if (end_sel == END_FRONT) mem[head] <= data_in;
        else                      mem[tail_dec] <= data_in;
      end else if (push) begin
        if (!full) begin
          if (end_sel == END_FRONT) begin
            mem[head_dec] <= data_in;
            head          <= head_dec;
          end else begin
            mem[tail] <= data_in;
            tail      <= tail_inc;
          end
          cnt <= cnt + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (pop) begin
        if (!empty) begin
          if (end_sel == END_FRONT) head <= head_inc;
          else                      tail <= tail_dec;
          cnt <= cnt - 1'b1;
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    front_out = '0;
    back_out  = '0;
    if (sel_q && !empty) begin
      front_out = mem[head];
      back_out  = mem[tail_dec];
    end
  end

endmodule

// File: tb/tb_deque.sv
// Randomised and directed scoreboard bench for deque (WORDS=16, ADDR=1),
// checked against a queue-based reference model.
module tb_deque;

  localparam int WIDTH = 8;
  localparam int WORDS = 16;
  localparam int ADDR  = 1;

  typedef struct {
    string      tag;
    logic [7:0] front;
    logic [7:0] back;
    logic [4:0] cnt;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [0:0]       select = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             end_sel = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] front_out, back_out;
  logic [4:0]       count;
  logic             empty, full, overflow, underflow;

  exp_t       sb[$];
  logic [7:0] model[$];
  logic       m_sel, m_ovf, m_unf;
  int         checks = 0;
  int         errors = 0;

  deque #(.WIDTH(WIDTH), .WORDS(WORDS), .ADDR(ADDR), .SELW(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .select    (select),
    .push      (push),
    .pop       (pop),
    .end_sel   (end_sel),
    .data_in   (data_in),
    .front_out (front_out),
    .back_out  (back_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one command for one cycle, advance the reference model and queue its expected outputs.
  task automatic applyStimulus(input string tag, input logic r, input logic s, input logic pu,
                               input logic po, input logic es, input logic [7:0] d);
    exp_t e;
    rst_n = r; select = s; push = pu; pop = po; end_sel = es; data_in = d;
    if (!r) begin
      model.delete();
      m_sel = 0; m_ovf = 0; m_unf = 0;
    end else if (s != 1'(ADDR)) begin
      m_sel = 0;
    end else begin
      m_sel = 1;
      if (pu && po && model.size() > 0) begin
        if (es == 1'b0) model[0] = d;
        else            model[model.size()-1] = d;
      end else if (pu) begin
        if (model.size() < WORDS) begin
          if (es == 1'b0) model.push_front(d);
          else            model.push_back(d);
        end else m_ovf = 1;
      end else if (po) begin
        if (model.size() > 0) begin
          if (es == 1'b0) void'(model.pop_front());
          else            void'(model.pop_back());
        end else m_unf = 1;
      end
    end
    e.tag   = tag;
    e.front = (m_sel && model.size() > 0) ? model[0] : 8'h00;
    e.back  = (m_sel && model.size() > 0) ? model[model.size()-1] : 8'h00;
    e.cnt   = 5'(model.size());
    e.empty = (model.size() == 0);
    e.full  = (model.size() == WORDS);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the deque presents fresh outputs after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.tag, ".front_out"}, 32'(front_out), 32'(e.front));
        checkOutput({e.tag, ".back_out"},  32'(back_out),  32'(e.back));
        checkOutput({e.tag, ".count"},     32'(count),     32'(e.cnt));
        checkOutput({e.tag, ".empty"},     32'(empty),     32'(e.empty));
        checkOutput({e.tag, ".full"},      32'(full),      32'(e.full));
        checkOutput({e.tag, ".overflow"},  32'(overflow),  32'(e.ovf));
        checkOutput({e.tag, ".underflow"}, 32'(underflow), 32'(e.unf));
      end
    end
  end

  initial begin
    m_sel = 0; m_ovf = 0; m_unf = 0;
    @(negedge clk);

    applyStimulus("reset0", 0, 1, 1, 0, 1, 8'hEE);
    applyStimulus("reset1", 0, 1, 1, 0, 1, 8'hEE);

    applyStimulus("order_push11", 1, 1, 1, 0, 1, 8'h11);
    applyStimulus("order_push22", 1, 1, 1, 0, 1, 8'h22);
    applyStimulus("order_push33", 1, 1, 1, 0, 1, 8'h33);
    applyStimulus("order_popf",   1, 1, 0, 1, 0, 8'h00);

    applyStimulus("wrap_reset",   0, 1, 0, 0, 0, 8'h00);
    applyStimulus("wrap_pushA0",  1, 1, 1, 0, 0, 8'hA0);
    applyStimulus("wrap_pushA1",  1, 1, 1, 0, 0, 8'hA1);

    applyStimulus("fill_reset",   0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < WORDS; i++)
      applyStimulus("fill_push", 1, 1, 1, 0, 1, 8'(i + 1));
    applyStimulus("fill_over",    1, 1, 1, 0, 1, 8'hFF);

    applyStimulus("repl_reset",   0, 1, 0, 0, 0, 8'h00);
    applyStimulus("repl_push55",  1, 1, 1, 0, 1, 8'h55);
    applyStimulus("repl_66",      1, 1, 1, 1, 1, 8'h66);
    applyStimulus("repl_pop1",    1, 1, 0, 1, 0, 8'h00);
    applyStimulus("repl_pop2",    1, 1, 0, 1, 0, 8'h00);
    applyStimulus("repl_pp_empty",1, 1, 1, 1, 0, 8'h5A);

    applyStimulus("gate_reset",   0, 0, 0, 0, 0, 8'h00);
    applyStimulus("gate_unsel",   1, 0, 1, 0, 1, 8'h99);
    applyStimulus("gate_push77",  1, 1, 1, 0, 1, 8'h77);
    applyStimulus("gate_idle",    1, 1, 0, 0, 0, 8'h00);
    applyStimulus("gate_off",     1, 0, 0, 1, 0, 8'h00);
    applyStimulus("gate_on",      1, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < 600; i++) begin
      logic r, s, pu, po;
      r  = ($urandom_range(0, 149) != 0);
      s  = ($urandom_range(0, 9) != 0);
      pu = (i % 200 < 110) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      po = ($urandom_range(0, 9) < 4);
      applyStimulus("rand", r, s, pu, po, 1'($urandom), 8'($urandom));
    end

    applyStimulus("final_idle", 1, 1, 0, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deque.md
# deque

Parametrised double-ended queue, the successor to the fixed 8-bit, 16-word single-ended stack. Stores WIDTH-bit words in a WORDS-entry circular buffer and supports push, pop and replace at either end, selected per cycle. It has occupancy count and sticky overflow/underflow flags, and is bus-addressed by a select code like its predecessor. Several instances sit behind the shared select bus on the top-level data path; each responds only to its own ADDR.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- WORDS, 16: capacity in words (≥2; need not be a power of two).
- ADDR, 0: select code this instance responds to.
- SELW, 1: width of the select bus.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- select  in  SELW  instance select; the instance is active when select == ADDR.
- push  in  1  push data_in at the chosen end.
- pop  in  1  pop from the chosen end.
- end_sel  in  1  0 = front, 1 = back.
- data_in  in  WIDTH  write data.
- front_out  out  WIDTH  front element; 0 if empty or not selected last cycle.
- back_out  out  WIDTH  back element; 0 if empty or not selected last cycle.
- count  out  $clog2(WORDS+1)  number of stored words.
- empty  out  1  count == 0.
- full  out  1  count == WORDS.
- overflow  out  1  sticky: a push was dropped because the deque was full.
- underflow  out  1  sticky: a pop was issued while the deque was empty.

## Operation
- State: head (index of front element), tail (index one past the back element), count, sel_q (registered "was selected"), overflow and underflow flags.
- Wrap rules: indices run 0..WORDS-1. Increment from WORDS-1 goes to 0. Decrement from 0 goes to WORDS-1. Wrap is explicit, not implied by bit width.
- Reset: memory cleared to 0, head = tail = count = 0, sel_q = 0, both flags 0.
  - Reset values of outputs: empty = 1, full = 0, count = 0, overflow = 0, underflow = 0, front_out = back_out = 0.
  - Reset takes priority over any simultaneous command.
- Not selected: no state change except sel_q <= 0.
- Selected: sel_q <= 1, then decode the command in this order:
  - push & pop & ~empty → replace. Write data_in over the element at the chosen end. Pointers and count are unchanged.
  - push & pop & empty → treat as a plain push; underflow is not set.
  - push & ~full:
    - front: head <= head−1, mem[head−1] <= data_in.
    - back: mem[tail] <= data_in, tail <= tail+1.
    - count <= count+1.
  - push & full → no change; overflow <= 1.
  - pop & ~empty:
    - front: head <= head+1.
    - back: tail <= tail−1.
    - count <= count−1.
    - Popped memory is not cleared.
  - pop & empty → no change; underflow <= 1.
- Reads are combinational:
  - front_out = mem[head].
  - back_out = mem[tail−1].
  - Both are forced to 0 when empty or ~sel_q.
- WORDS = 1 is not supported; front and back always refer to distinct indices unless count == 1, when both show the same element.

## Timing
- Writes and pointer/count updates become visible one cycle after the command edge. The new front_out/back_out/count are valid in the cycle after the command.
- A command needs no handshake and completes in one cycle, so one command is accepted per cycle.
- empty and full are decoded from the registered count, so they never glitch relative to the data.
- Output gating on sel_q lags select by one cycle: outputs become nonzero the cycle after select first matches ADDR.
- Flags set on the edge of the offending command and stay set until rst_n is asserted.

## Structure
- Package deque_pkg holds:
  - END_FRONT = 1'b0 and END_BACK = 1'b1.
  - the function computing the count width from WORDS.
- Sub-module deque_ring_ptr: parametrised by WORDS. Combinational inc/dec of an index with explicit wrap. Instantiated for head±1 and tail±1.
- Memory is a flat register array; no SRAM macro.

## Test plan
- Reset, WORDS=16: assert rst_n=0 for 2 cycles → empty=1, count=0, both flags 0, front_out=back_out=0.
- Back-to-front ordering: push back 0x11, 0x22, 0x33 → front_out=0x11, back_out=0x33, count=3. Then pop front → front_out=0x22, count=2.
- Front push across wrap from head=0: push front 0xA0 then 0xA1 → head=15 then 14, front_out=0xA1, back_out=0xA0.
- Fill and overflow: 16 pushes back → full=1. A 17th push with 0xFF → count stays 16, overflow=1, back_out unchanged.
- Replace and underflow:
  - On count=1 holding 0x55, push&pop at the back with 0x66 → count=1, front_out=back_out=0x66.
  - Pop twice → the first pop gives empty=1; the second gives underflow=1 with count=0.
- Select gating with ADDR=1:
  - select=0 with push → no change.
  - select=1 → push accepted; front_out becomes nonzero the next cycle.
  - select back to 0 → outputs 0 one cycle later, contents retained.
